proximity_alarm: RTL and testbench

Downstream consumer of the ultrasonic ranging stage. Takes each new distance measurement (cm, with a one-cycle valid strobe) and smooths it with a 4-sample moving average. It classifies the average into an alert zone, confirming zone changes before acting on them. It then drives the piezo buzzer with a zone-dependent beep cadence and drives the LEDR bar graph. If measurements stop arriving, it declares the sensor stale and goes silent.

---
 rtl/proximity_pkg.sv | 21 ++
 rtl/proximity_alarm_beep_gen.sv | 74 +++++++
 rtl/proximity_alarm.sv | 130 +++++++++++++
 tb/tb_proximity_alarm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/proximity_pkg.sv
// Shared types and constants for the proximity alarm: zone and beep-state
// encodings plus the distance saturation value and width.
package proximity_pkg;

  localparam int unsigned MAX_CM = 400;
  localparam int          DIST_W = 9;

  typedef enum logic [1:0] {
    FAR  = 2'd0,
    WARN = 2'd1,
    NEAR = 2'd2,
    CRIT = 2'd3
  } zone_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } beep_state_t;

endpackage

// File: rtl/proximity_alarm_beep_gen.sv
// Beep cadence generator: turns the confirmed zone into a gated square wave
// for the piezo. Any zone change restarts the pattern from its beginning.
module beep_gen
  import proximity_pkg::*;
#(
  parameter int TONE_HALF   = 12500,
  parameter int ON_CYC      = 5_000_000,
  parameter int WARN_PERIOD = 25_000_000,
  parameter int NEAR_PERIOD = 12_500_000
) (
  input  logic  clock,
  input  logic  RESET,
  input  zone_t zone,
  output logic  buzz_out
);

  beep_state_t state, state_nxt;
  zone_t       zone_q;
  logic [31:0] phase_cnt;
  logic [31:0] tone_cnt;
  logic [31:0] off_len;
  logic        restart;

  assign off_len = (zone == WARN) ? 32'(WARN_PERIOD - ON_CYC)
                                  : 32'(NEAR_PERIOD - ON_CYC);

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    if (zone != zone_q) begin
      restart   = 1'b1;
      state_nxt = (zone == FAR) ? IDLE : ON;
    end else begin
      case (state)
        IDLE: if (zone != FAR) begin
          restart   = 1'b1;
          state_nxt = ON;
        end
        // CRIT never leaves ON; the other beeping zones alternate ON/OFF
        ON:  if (zone != CRIT && phase_cnt == 32'(ON_CYC - 1)) state_nxt = OFF;
        OFF: if (phase_cnt == off_len - 32'd1) state_nxt = ON;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!RESET) begin
      state     <= IDLE;
      zone_q    <= FAR;
      phase_cnt <= '0;
      tone_cnt  <= '0;
      buzz_out  <= 1'b0;
    end else begin
      state  <= state_nxt;
      zone_q <= zone;
      if (restart || state_nxt != state) phase_cnt <= '0;
      else                               phase_cnt <= phase_cnt + 32'd1;
      // Tone runs only while staying in ON; every ON entry starts low
      if (state_nxt == ON && state == ON && !restart) begin
        if (tone_cnt == 32'(TONE_HALF - 1)) begin
          tone_cnt <= '0;
          buzz_out <= ~buzz_out;
        end else begin
          tone_cnt <= tone_cnt + 32'd1;
        end
      end else begin
        tone_cnt <= '0;
        buzz_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/proximity_alarm.sv
// Proximity alarm: saturates and averages range samples, confirms alert
// zones, drives the LED bar and the beep generator, and flags a stale sensor.
module proximity_alarm
  import proximity_pkg::*;
#(
  parameter int FAR_CM      = 100,
  parameter int WARN_CM     = 50,
  parameter int CRIT_CM     = 20,
  parameter int TONE_HALF   = 12500,
  parameter int ON_CYC      = 5_000_000,
  parameter int WARN_PERIOD = 25_000_000,
  parameter int NEAR_PERIOD = 12_500_000,
  parameter int STALE_CYC   = 10_000_000
) (
  input  logic              clock,
  input  logic              RESET,
  input  logic [31:0]       dist_cm,
  input  logic              dist_valid,
  output logic              buzz_out,
  output logic [9:0]        LEDR,
  output logic [1:0]        zone,
  output logic [DIST_W-1:0] avg_cm,
  output logic              stale
);

  localparam logic [10:0] FILL_SUM = 11'(4 * MAX_CM);

  function automatic logic [DIST_W-1:0] sat_dist(input logic [31:0] d);
    return (d > 32'(MAX_CM)) ? DIST_W'(MAX_CM) : d[DIST_W-1:0];
  endfunction

  function automatic zone_t classify(input logic [DIST_W-1:0] a);
    if (int'(a) >= FAR_CM)  return FAR;
    if (int'(a) >= WARN_CM) return WARN;
    if (int'(a) >= CRIT_CM) return NEAR;
    return CRIT;
  endfunction

  function automatic logic [9:0] bar_graph(input logic [DIST_W-1:0] a);
    logic [9:0] b;
    for (int i = 0; i < 10; i++) b[i] = (int'(a) < 40 * (i + 1));
    return b;
  endfunction

  logic [DIST_W-1:0] sample_p0;
  logic              vld_p0;
  logic [DIST_W-1:0] smp_p1 [4];
  logic [10:0]       sum_p1;
  logic [10:0]       sum_nxt;
  logic              vld_p1;
  zone_t             zone_p2;
  zone_t             cand_p2;
  zone_t             new_cand;
  logic [31:0]       idle_cnt;
  logic              stale_set;

  assign stale_set = !dist_valid && (idle_cnt == 32'(STALE_CYC - 1));
  assign sum_nxt   = sum_p1 + {2'b00, sample_p0} - {2'b00, smp_p1[3]};
  assign new_cand  = classify(avg_cm);
  assign zone      = zone_p2;

  // Stage 0: capture saturated sample
  always_ff @(posedge clock) begin
    if (!RESET) vld_p0 <= 1'b0;
    else        vld_p0 <= dist_valid;
    sample_p0 <= sat_dist(dist_cm);
  end

  // Stage 1: shift buffer and running sum; stale refills with MAX_CM
  always_ff @(posedge clock) begin
    if (!RESET) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
    if (!RESET || stale_set) begin
      for (int i = 0; i < 4; i++) smp_p1[i] <= DIST_W'(MAX_CM);
      sum_p1 <= FILL_SUM;
      avg_cm <= DIST_W'(MAX_CM);
    end else if (vld_p0) begin
      smp_p1[0] <= sample_p0;
      for (int i = 1; i < 4; i++) smp_p1[i] <= smp_p1[i-1];
      sum_p1 <= sum_nxt;
      avg_cm <= sum_nxt[10:2];
    end
  end

  // Stage 2: zone confirmation and LED bar
  always_ff @(posedge clock) begin
    if (!RESET || stale_set) begin
      zone_p2 <= FAR;
      cand_p2 <= FAR;
      LEDR    <= '0;
    end else if (vld_p1) begin
      LEDR <= bar_graph(avg_cm);
      if (new_cand == zone_p2) begin
        cand_p2 <= zone_p2;
      end else if (new_cand == CRIT || new_cand == cand_p2) begin
        zone_p2 <= new_cand;
        cand_p2 <= new_cand;
      end else begin
        cand_p2 <= new_cand;
      end
    end
  end

  // Idle counter saturates at STALE_CYC; a strobe always wins over stale
  always_ff @(posedge clock) begin
    if (!RESET) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else if (dist_valid) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else if (idle_cnt != 32'(STALE_CYC)) begin
      idle_cnt <= idle_cnt + 32'd1;
      if (stale_set) stale <= 1'b1;
    end
  end

  beep_gen #(
    .TONE_HALF  (TONE_HALF),
    .ON_CYC     (ON_CYC),
    .WARN_PERIOD(WARN_PERIOD),
    .NEAR_PERIOD(NEAR_PERIOD)
  ) u_beep (
    .clock   (clock),
    .RESET   (RESET),
    .zone    (zone_p2),
    .buzz_out(buzz_out)
  );

endmodule

// File: tb/tb_proximity_alarm.sv
// Bench for proximity_alarm: directed scenarios plus randomized strobe
// traffic, every cycle compared against a behavioural model.
module tb_proximity_alarm;

  localparam int TONE_HALF   = 4;
  localparam int ON_CYC      = 20;
  localparam int NEAR_PERIOD = 50;
  localparam int WARN_PERIOD = 100;
  localparam int STALE_CYC   = 500;
  localparam int FAR_CM      = 100;
  localparam int WARN_CM     = 50;
  localparam int CRIT_CM     = 20;
  localparam int MAXC        = 400;

  logic        clock = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] dist_cm = '0;
  logic        dist_valid = 1'b0;
  logic        buzz_out;
  logic [9:0]  LEDR;
  logic [1:0]  zone;
  logic [8:0]  avg_cm;
  logic        stale;

  proximity_alarm #(
    .FAR_CM(FAR_CM), .WARN_CM(WARN_CM), .CRIT_CM(CRIT_CM),
    .TONE_HALF(TONE_HALF), .ON_CYC(ON_CYC),
    .WARN_PERIOD(WARN_PERIOD), .NEAR_PERIOD(NEAR_PERIOD),
    .STALE_CYC(STALE_CYC)
  ) dut (
    .clock(clock), .RESET(RESET), .dist_cm(dist_cm), .dist_valid(dist_valid),
    .buzz_out(buzz_out), .LEDR(LEDR), .zone(zone), .avg_cm(avg_cm),
    .stale(stale)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state: sample history, pending strobes, zone logic,
  // and the beep pattern as elapsed time since the pattern started.
  int m_smp [4];
  bit m_p0, m_p1;
  int m_s0;
  int m_avg, m_zone, m_cand, m_led, m_stale, m_idle, m_bz, m_t;

  function automatic int classify(input int a);
    if (a >= FAR_CM)  return 0;
    if (a >= WARN_CM) return 1;
    if (a >= CRIT_CM) return 2;
    return 3;
  endfunction

  function automatic int bar(input int a);
    int r = 0;
    for (int i = 0; i < 10; i++) if (a < 40 * (i + 1)) r |= (1 << i);
    return r;
  endfunction

  function automatic int exp_buzz();
    int per, pos;
    if (m_bz == 0) return 0;
    if (m_bz == 3) return (m_t / TONE_HALF) % 2;
    per = (m_bz == 1) ? WARN_PERIOD : NEAR_PERIOD;
    pos = m_t % per;
    return (pos < ON_CYC) ? (pos / TONE_HALF) % 2 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_smp[i] = MAXC;
    m_p0 = 0; m_p1 = 0; m_s0 = 0;
    m_avg = MAXC; m_zone = 0; m_cand = 0; m_led = 0;
    m_stale = 0; m_idle = 0; m_bz = 0; m_t = 0;
  endtask

  task automatic model_edge(input bit v, input int unsigned d);
    int c;
    if (m_zone != m_bz) begin m_bz = m_zone; m_t = 0; end
    else m_t++;
    if (m_p1) begin
      c = classify(m_avg);
      m_led = bar(m_avg);
      if (c == m_zone) m_cand = c;
      else if (c == 3 || c == m_cand) begin m_zone = c; m_cand = c; end
      else m_cand = c;
    end
    if (m_p0) begin
      for (int i = 3; i > 0; i--) m_smp[i] = m_smp[i-1];
      m_smp[0] = m_s0;
      m_avg = (m_smp[0] + m_smp[1] + m_smp[2] + m_smp[3]) / 4;
    end
    m_p1 = m_p0;
    if (v) begin
      m_idle = 0; m_stale = 0;
    end else if (m_idle < STALE_CYC) begin
      m_idle++;
      if (m_idle == STALE_CYC) begin
        m_stale = 1;
        for (int i = 0; i < 4; i++) m_smp[i] = MAXC;
        m_avg = MAXC; m_zone = 0; m_cand = 0; m_led = 0;
      end
    end
    m_p0 = v;
    m_s0 = (d > MAXC) ? MAXC : int'(d);
  endtask

  task automatic step(input bit v, input int unsigned d);
    dist_valid = v;
    dist_cm    = d;
    @(posedge clock);
    if (!RESET) model_reset();
    else        model_edge(v, d);
    #1;
    chk("avg_cm", 32'(avg_cm), 32'(m_avg));
    chk("zone", 32'(zone), 32'(m_zone));
    chk("LEDR", 32'(LEDR), 32'(m_led));
    chk("stale", 32'(stale), 32'(m_stale));
    chk("buzz_out", 32'(buzz_out), 32'(exp_buzz()));
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b0;
    repeat (n) step(0, 0);
    RESET = 1'b1;
  endtask

  task automatic strobe(input int unsigned d, input int gap);
    step(1, d);
    repeat (gap) step(0, 0);
  endtask

  function automatic int unsigned rand_dist();
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return $urandom_range(0, 25);
      default: return $urandom_range(0, 140);
    endcase
  endfunction

  initial begin
    // Reset state
    do_reset(3);
    chk("rst_avg", 32'(avg_cm), 32'd400);
    chk("rst_zone", 32'(zone), 32'd0);
    chk("rst_led", 32'(LEDR), 32'd0);
    chk("rst_buzz", 32'(buzz_out), 32'd0);

    // Averaging and saturation
    strobe(1000, 1); chk("avg_sat", 32'(avg_cm), 32'd400);
    strobe(30, 1);   chk("avg_307", 32'(avg_cm), 32'd307);
    strobe(30, 1);   chk("avg_215", 32'(avg_cm), 32'd215);
    strobe(30, 1);   chk("avg_122", 32'(avg_cm), 32'd122);
    strobe(30, 2);   chk("avg_30", 32'(avg_cm), 32'd30);
    chk("led_30", 32'(LEDR), 32'h3FF);

    // WARN confirmation and cadence
    do_reset(2);
    repeat (4) strobe(70, 2);
    chk("warn_hold", 32'(zone), 32'd0);
    strobe(70, 2);
    chk("warn_set", 32'(zone), 32'd1);
    repeat (230) step(0, 0);

    // CRITICAL fast path
    do_reset(2);
    repeat (4) step(1, 0);
    repeat (2) step(0, 0);
    chk("crit_set", 32'(zone), 32'd3);
    repeat (60) step(0, 0);

    // Stale, then recovery
    repeat (440) step(0, 0);
    chk("stale_set", 32'(stale), 32'd1);
    chk("stale_zone", 32'(zone), 32'd0);
    chk("stale_led", 32'(LEDR), 32'd0);
    step(0, 0);
    chk("stale_buzz", 32'(buzz_out), 32'd0);
    strobe(10, 1);
    chk("stale_clr", 32'(stale), 32'd0);
    chk("stale_avg", 32'(avg_cm), 32'd302);

    // Strobe exactly at the stale boundary
    step(1, 200);
    repeat (STALE_CYC - 1) step(0, 0);
    step(1, 200);
    chk("stale_race", 32'(stale), 32'd0);

    // NEAR then CRITICAL while in the OFF phase
    do_reset(2);
    repeat (5) strobe(30, 2);
    chk("near_set", 32'(zone), 32'd2);
    repeat (25) step(0, 0);
    strobe(0, 2);
    strobe(0, 30);
    chk("near_to_crit", 32'(zone), 32'd3);

    // Randomized traffic
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 9))
        0: do_reset($urandom_range(1, 3));
        1, 2: repeat ($urandom_range(1, 8)) step(1, rand_dist());
        3: repeat ($urandom_range(STALE_CYC - 3, STALE_CYC + 40)) step(0, 0);
        4: begin
          step(1, rand_dist());
          repeat ($urandom_range(STALE_CYC - 2, STALE_CYC)) step(0, 0);
          step(1, rand_dist());
        end
        default: repeat ($urandom_range(2, 10))
          strobe(rand_dist(), $urandom_range(0, 120));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
